spi_cmd_ram_param: RTL and testbench

//   Parametrised command-driven single-port RAM behind the SPI slave. Decodes
//   2-bit opcode + payload words from the slave (rx_valid/din) and returns read

---
 rtl/spi_cmd_ram_param_if.sv | 14 +
 rtl/spi_cmd_ram_param.sv | 108 ++++++++++
 tb/tb_spi_cmd_ram_param.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_ram_param_if.sv
// Command/response bus between the SPI slave front end and the command RAM.
// master = SPI slave side (issues commands), slave = RAM side (answers).
interface spi_cmd_ram_param_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W+1:0] din;
   logic              rx_valid;
   logic [WORD_W-1:0] dout;
   logic              tx_valid;
   logic              err;

   modport master (output din, rx_valid, input  dout, tx_valid, err);
   modport slave  (input  din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/spi_cmd_ram_param.sv
// Command-driven single-port RAM: 2-bit opcode + payload in, read data out,
// with independent armed write/read pointers, optional auto-increment and error pulses.
module spi_cmd_ram_param #(
   parameter int WORD_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AUTO_INC  = 1
) (
   input  logic               clk,
   input  logic               rst,
   spi_cmd_ram_param_if.slave bus
);
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [AW-1:0] LAST_PTR = AW'(MEM_DEPTH - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ARMED = 1'b1;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef struct packed {
      logic [1:0]        op;
      logic [WORD_W-1:0] pl;
   } cmd_t;

   cmd_t              cmd;
   logic              in_range;
   logic [AW-1:0]     pl_ptr;
   logic              is_wa, is_wd, is_ra, is_rd;
   logic              wr_acc, rd_acc, err_nxt;

   logic [WORD_W-1:0] mem [MEM_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [0:0]        wr_st, rd_st;
   logic [WORD_W-1:0] dout_q;
   logic              tx_valid_q, err_q;

   assign cmd = bus.din;

   // Widened compare also rejects any payload bits above the pointer width.
   assign in_range = {1'b0, cmd.pl} < (WORD_W+1)'(MEM_DEPTH);
   assign pl_ptr   = cmd.pl[AW-1:0];

   assign is_wa = bus.rx_valid && (cmd.op == OP_WR_ADDR);
   assign is_wd = bus.rx_valid && (cmd.op == OP_WR_DATA);
   assign is_ra = bus.rx_valid && (cmd.op == OP_RD_ADDR);
   assign is_rd = bus.rx_valid && (cmd.op == OP_RD_DATA);

   assign wr_acc  = is_wd && (wr_st == ST_ARMED);
   assign rd_acc  = is_rd && (rd_st == ST_ARMED);
   assign err_nxt = ((is_wa || is_ra) && !in_range) ||
                    (is_wd && (wr_st != ST_ARMED)) ||
                    (is_rd && (rd_st != ST_ARMED));

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_st      <= ST_IDLE;
         rd_st      <= ST_IDLE;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tx_valid_q <= rd_acc;
         err_q      <= err_nxt;

         if (is_wa) begin
            if (in_range) begin
               wr_ptr <= pl_ptr;
               wr_st  <= ST_ARMED;
            end else begin
               wr_st  <= ST_IDLE;
            end
         end else if (wr_acc && (AUTO_INC != 0)) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end

         if (is_ra) begin
            if (in_range) begin
               rd_ptr <= pl_ptr;
               rd_st  <= ST_ARMED;
            end else begin
               rd_st  <= ST_IDLE;
            end
         end else if (rd_acc && (AUTO_INC != 0)) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end

         if (rd_acc) dout_q <= mem[rd_ptr];
      end
   end

   // Contents survive reset; a write lands before a read issued the next cycle.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= cmd.pl;
   end

   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_cmd_ram_param.sv
// Scoreboarded bench: three DUT configurations (256/inc, 200/inc, 256/no-inc)
// driven one command per cycle from a shared reference model.
module tb_spi_cmd_ram_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_cmd_ram_param_if #(.WORD_W(8)) bus0 ();
   spi_cmd_ram_param_if #(.WORD_W(8)) bus1 ();
   spi_cmd_ram_param_if #(.WORD_W(8)) bus2 ();

   spi_cmd_ram_param #(.WORD_W(8), .MEM_DEPTH(256), .AUTO_INC(1))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   spi_cmd_ram_param #(.WORD_W(8), .MEM_DEPTH(200), .AUTO_INC(1))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   spi_cmd_ram_param #(.WORD_W(8), .MEM_DEPTH(256), .AUTO_INC(0))
      u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   logic [9:0] din_a [3];
   logic       rxv_a [3];
   logic [7:0] dout_o [3];
   logic       tx_o [3];
   logic       err_o [3];

   assign bus0.din = din_a[0]; assign bus0.rx_valid = rxv_a[0];
   assign bus1.din = din_a[1]; assign bus1.rx_valid = rxv_a[1];
   assign bus2.din = din_a[2]; assign bus2.rx_valid = rxv_a[2];
   assign dout_o[0] = bus0.dout; assign tx_o[0] = bus0.tx_valid; assign err_o[0] = bus0.err;
   assign dout_o[1] = bus1.dout; assign tx_o[1] = bus1.tx_valid; assign err_o[1] = bus1.err;
   assign dout_o[2] = bus2.dout; assign tx_o[2] = bus2.tx_valid; assign err_o[2] = bus2.err;

   typedef struct packed {
      logic [1:0] k;
      logic       is_err;
      logic [7:0] d;
   } exp_t;

   exp_t sbq [$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // reference model state
   logic [7:0] mmem [3][256];
   int         wp [3], rp [3];
   bit         wok [3], rok [3];
   logic [7:0] md [3];
   int         dep [3] = '{256, 200, 256};
   bit         inc [3] = '{1'b1, 1'b1, 1'b0};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input int k, input bit is_err, input logic [7:0] d);
      exp_t e;
      e.k = 2'(k); e.is_err = is_err; e.d = d;
      sbq.push_back(e);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         wp[k] = 0; rp[k] = 0; wok[k] = 0; rok[k] = 0; md[k] = 8'h00;
      end
   endtask

   task automatic send(input int k, input logic [9:0] c);
      int pl;
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) rxv_a[j] = 1'b0;
      din_a[k] = c;
      rxv_a[k] = 1'b1;
      pl = int'(c[7:0]);
      case (c[9:8])
         2'b00: if (pl < dep[k]) begin wp[k] = pl; wok[k] = 1; end
                else begin wok[k] = 0; push_exp(k, 1, md[k]); end
         2'b01: if (wok[k]) begin
                   mmem[k][wp[k]] = c[7:0];
                   if (inc[k]) wp[k] = (wp[k] == dep[k] - 1) ? 0 : wp[k] + 1;
                end else push_exp(k, 1, md[k]);
         2'b10: if (pl < dep[k]) begin rp[k] = pl; rok[k] = 1; end
                else begin rok[k] = 0; push_exp(k, 1, md[k]); end
         default: if (rok[k]) begin
                   md[k] = mmem[k][rp[k]];
                   push_exp(k, 0, md[k]);
                   if (inc[k]) rp[k] = (rp[k] == dep[k] - 1) ? 0 : rp[k] + 1;
                end else push_exp(k, 1, md[k]);
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         for (int j = 0; j < 3; j++) rxv_a[j] = 1'b0;
      end
   endtask

   // Every tx_valid/err pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (tx_o[k] || err_o[k]) begin
               if (sbq.size() == 0) begin
                  chk($sformatf("unexpected_pulse_dut%0d", k), {30'd0, tx_o[k], err_o[k]}, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  chk($sformatf("sb_dut%0d", k),
                      {20'd0, 2'(k), err_o[k], tx_o[k], dout_o[k]},
                      {20'd0, e.k, e.is_err, ~e.is_err, e.d});
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int j = 0; j < 3; j++) begin din_a[j] = '0; rxv_a[j] = 1'b0; end
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset_state_dut%0d", k), {22'd0, tx_o[k], err_o[k], dout_o[k]}, 32'd0);
      @(negedge clk) rst = 1'b0;

      // after reset: reads and writes unarmed -> err, dout stays 0
      send(0, 10'h300);
      send(0, 10'h155);

      // fill memories so any later read is defined
      send(0, 10'h000);
      for (int i = 0; i < 256; i++) send(0, {2'b01, 8'($urandom)});
      send(1, 10'h000);
      for (int i = 0; i < 200; i++) send(1, {2'b01, 8'($urandom)});
      for (int i = 0; i < 256; i++) begin
         send(2, {2'b00, 8'(i)});
         send(2, {2'b01, 8'($urandom)});
      end

      // basic write/read
      send(0, 10'h012); send(0, 10'h1A5); send(0, 10'h212); send(0, 10'h300);
      // auto-increment wrap, back-to-back reads
      send(0, 10'h0FF); send(0, 10'h111); send(0, 10'h122);
      send(0, 10'h2FF); send(0, 10'h300); send(0, 10'h300);
      // write then read the same address next cycle, random RD_DATA payload
      send(0, 10'h030); send(0, 10'h230); send(0, 10'h177); send(0, {2'b11, 8'($urandom)});

      // MEM_DEPTH=200 range rules and wrap at 199
      send(1, 10'h0C8); send(1, 10'h1AA);
      send(1, 10'h0C7); send(1, 10'h1AA); send(1, 10'h1BB);
      send(1, 10'h2C7); send(1, 10'h300); send(1, 10'h300);
      send(1, 10'h2FF); send(1, 10'h300);

      // no auto-increment: same word twice
      send(2, 10'h010); send(2, 10'h15A); send(2, 10'h15B);
      send(2, 10'h210); send(2, 10'h300); send(2, 10'h300);

      idle(2);

      // async reset while tx_valid is high; memory survives
      send(0, 10'h000); send(0, 10'h1C3); send(0, 10'h200); send(0, 10'h300);
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) rxv_a[j] = 1'b0;
      #1;
      chk("pre_reset_read", {23'd0, tx_o[0], dout_o[0]}, {23'd0, 1'b1, 8'hC3});
      if (sbq.size() != 0) void'(sbq.pop_front());
      rst = 1'b1;
      #1;
      chk("async_reset_clears", {22'd0, tx_o[0], err_o[0], dout_o[0]}, 32'd0);
      model_reset();
      @(negedge clk) rst = 1'b0;
      send(0, 10'h300);
      send(0, 10'h155);
      send(0, 10'h200);
      send(0, 10'h300);

      // random interleaved traffic on all three configurations
      for (int i = 0; i < 600; i++) send(int'($urandom_range(0, 2)), 10'($urandom));

      idle(3);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
